// File: rtl/sig_a_arb_pkg.sv
// Shared types, defaults and the widening helper for the sig_a round-robin arbiter.
package sig_a_arb_pkg;

   localparam int unsigned DefNumReq = 4;
   localparam int unsigned DefDataW  = 2;
   localparam int unsigned DefOutW   = 3;
   localparam int unsigned MaxW      = 32;

   typedef enum logic [0:0] {
      IDLE,
      SEND
   } arb_state_e;

   // Clears everything above data_w; callers slice the result down to OUT_W.
   function automatic logic [MaxW-1:0] zext_sig_a(input logic [MaxW-1:0] data,
                                                  input int unsigned     data_w);
      logic [MaxW-1:0] mask;
      mask = (data_w >= MaxW) ? '1 : ((MaxW'(1) << data_w) - MaxW'(1));
      return data & mask;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest set request at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned GID_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GID_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [GID_W-1:0]   gnt_id,
   output logic               any
);

   logic [NUM_REQ-1:0]   hi_mask;
   logic [2*NUM_REQ-1:0] dbl;
   logic                 found;

   always_comb begin
      // Lower copy keeps only requests at or above ptr; upper copy supplies the wrap.
      hi_mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
      dbl     = {req, req & hi_mask};
      found   = 1'b0;
      gnt_id  = '0;
      for (int unsigned j = 0; j < 2 * NUM_REQ; j++) begin
         if (!found && dbl[j]) begin
            found  = 1'b1;
            gnt_id = GID_W'(j % NUM_REQ);
         end
      end
      gnt = '0;
      if (found) begin
         gnt[gnt_id] = 1'b1;
      end
      any = found;
   end

endmodule

// File: rtl/sig_a_arbiter.sv
// Round-robin arbiter sharing one registered, zero-extended sig_a port among NUM_REQ requesters.
module sig_a_arbiter
   import sig_a_arb_pkg::*;
#(
   parameter int unsigned  NUM_REQ = DefNumReq,
   parameter int unsigned  DATA_W  = DefDataW,
   parameter int unsigned  OUT_W   = DefOutW,
   localparam int unsigned GID_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [OUT_W-1:0]          sig_a,
   output logic                      sig_a_valid,
   input  logic                      sig_a_ready,
   output logic [GID_W-1:0]          grant_id,
   output logic                      busy
);

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("sig_a_arbiter: NUM_REQ must be 2..16");
   end
   if (OUT_W < DATA_W || OUT_W > MaxW) begin : g_bad_out_w
      $error("sig_a_arbiter: OUT_W must be >= DATA_W and <= 32");
   end

   arb_state_e         state;
   logic [GID_W-1:0]   rr_ptr;
   logic [GID_W-1:0]   next_ptr;
   logic [NUM_REQ-1:0] gnt;
   logic [GID_W-1:0]   gnt_id;
   logic               any;
   logic               accept;
   logic [DATA_W-1:0]  win_data;
   logic [OUT_W-1:0]   win_ext;

   rr_pick #(
      .NUM_REQ(NUM_REQ),
      .GID_W  (GID_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .gnt   (gnt),
      .gnt_id(gnt_id),
      .any   (any)
   );

   // The output stage can take a new value when empty or when the child drains it this cycle.
   assign accept    = (state == IDLE) || sig_a_ready;
   assign req_ready = (accept && rst_n) ? gnt : '0;
   assign win_data  = req_data[gnt_id*DATA_W +: DATA_W];
   assign win_ext   = OUT_W'(zext_sig_a(MaxW'(win_data), DATA_W));
   assign next_ptr  = (gnt_id == GID_W'(NUM_REQ - 1)) ? '0 : gnt_id + GID_W'(1);
   assign busy      = sig_a_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sig_a       <= '0;
         sig_a_valid <= 1'b0;
         grant_id    <= '0;
         rr_ptr      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  state       <= SEND;
                  sig_a       <= win_ext;
                  sig_a_valid <= 1'b1;
                  grant_id    <= gnt_id;
                  rr_ptr      <= next_ptr;
               end
            end
            SEND: begin
               if (sig_a_ready) begin
                  if (any) begin
                     sig_a    <= win_ext;
                     grant_id <= gnt_id;
                     rr_ptr   <= next_ptr;
                  end else begin
                     state       <= IDLE;
                     sig_a_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               sig_a_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
